mem_arbiter: RTL

//  Sits between the I-cache and D-cache fill FSMs and the single pipelined main memory.
//  - Arbitrates block-fill misses from both caches and write-through stores from the D-cache.
//  - For a granted miss, issues WORDS read requests on consecutive cycles from the block-aligned address.
//  - Steers each returning word (mem_valid_in) to the owning cache as its memory_data / memory_data_valid.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the I/D cache fill FSMs, main memory and mem_arbiter.
// slave = arbiter side, master = caches/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_miss;
  logic [ADDR_W-1:0] i_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_addr;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_valid_in;
  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              i_grant;
  logic              d_grant;
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic [DATA_W-1:0] d_data;
  logic              d_valid;
  logic              d_wr_ack;

  modport slave (
    input  i_miss, i_addr, d_miss, d_addr, d_wr_req, d_wr_addr, d_wr_data,
           mem_data_in, mem_valid_in,
    output mem_enable, mem_wr, mem_addr, mem_wdata, i_grant, d_grant,
           i_data, i_valid, d_data, d_valid, d_wr_ack
  );

  modport master (
    output i_miss, i_addr, d_miss, d_addr, d_wr_req, d_wr_addr, d_wr_data,
           mem_data_in, mem_valid_in,
    input  mem_enable, mem_wr, mem_addr, mem_wdata, i_grant, d_grant,
           i_data, i_valid, d_data, d_valid, d_wr_ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates I/D cache block fills and D-cache write-through stores onto one pipelined memory.
// Define ARB_RR_EN for round-robin between fill requests (stores always win).
module mem_arbiter #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, ISSUE, DRAIN} state_t;

  localparam int                CW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0]     LAST     = CW'(WORDS - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * WORDS - 1);

  state_t            state, state_nx;
  logic [CW-1:0]     issue_cnt, ret_cnt;
  logic [ADDR_W-1:0] base, base_nx;
  logic              owner_d, owner_d_nx;
  logic              pick_d, accept, ret, fill_nx;

`ifdef ARB_RR_EN
  logic last_i;

  // On a tie, serve the cache that did not get the previous fill.
  assign pick_d = bus.d_miss && (!bus.i_miss || last_i);

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_i <= 1'b1;
    else if (accept)
      last_i <= !owner_d_nx;
  end
`else
  assign pick_d = bus.d_miss;
`endif

  always_comb begin
    state_nx       = state;
    base_nx        = base;
    owner_d_nx     = owner_d;
    accept         = 1'b0;
    ret            = 1'b0;
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.d_wr_ack   = 1'b0;
    // Outputs are forced quiet while reset is held so a burst in flight is dropped at once.
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (bus.d_wr_req) begin
            state_nx = WRITE;
          end else if (bus.d_miss || bus.i_miss) begin
            accept     = 1'b1;
            owner_d_nx = pick_d;
            base_nx    = (pick_d ? bus.d_addr : bus.i_addr) & ~BLK_MASK;
            state_nx   = ISSUE;
          end
        end
        WRITE: begin
          bus.mem_enable = 1'b1;
          bus.mem_wr     = 1'b1;
          bus.mem_addr   = bus.d_wr_addr;
          bus.mem_wdata  = bus.d_wr_data;
          bus.d_wr_ack   = 1'b1;
          state_nx       = IDLE;
        end
        ISSUE: begin
          bus.mem_enable = 1'b1;
          bus.mem_addr   = base | ADDR_W'({issue_cnt, 1'b0});
          ret            = bus.mem_valid_in;
          if (issue_cnt == LAST)
            state_nx = DRAIN;
        end
        DRAIN: begin
          ret = bus.mem_valid_in;
          if (ret && ret_cnt == LAST)
            state_nx = IDLE;
        end
      endcase
    end
    fill_nx     = (state_nx == ISSUE) || (state_nx == DRAIN);
    bus.i_valid = ret && !owner_d;
    bus.d_valid = ret && owner_d;
    bus.i_data  = bus.i_valid ? bus.mem_data_in : '0;
    bus.d_data  = bus.d_valid ? bus.mem_data_in : '0;
  end

  // Counters wrap naturally inside the block; both restart when a new fill is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      base        <= '0;
      owner_d     <= 1'b0;
      bus.i_grant <= 1'b0;
      bus.d_grant <= 1'b0;
    end else begin
      state       <= state_nx;
      base        <= base_nx;
      owner_d     <= owner_d_nx;
      bus.i_grant <= fill_nx && !owner_d_nx;
      bus.d_grant <= fill_nx && owner_d_nx;
      if (accept) begin
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        if (state == ISSUE)
          issue_cnt <= issue_cnt + CW'(1);
        if (ret)
          ret_cnt <= ret_cnt + CW'(1);
      end
    end
  end

endmodule
